// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// register offsets, CTRL bit positions and the CTRL register layout.
package timer_pkg;

    localparam logic [4:0] TMR_CTRL   = 5'h00;
    localparam logic [4:0] TMR_LOAD   = 5'h04;
    localparam logic [4:0] TMR_COUNT  = 5'h08;
    localparam logic [4:0] TMR_STATUS = 5'h0C;
    localparam logic [4:0] TMR_CMP    = 5'h10;

    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_AR = 1;
    localparam int unsigned CTRL_IE = 2;

    typedef struct packed {
        logic ie;
        logic ar;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/mmio_timer_if.sv
// Data-bus responder interface between the core/chipset and the timer.
interface mmio_timer_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;

    modport master (output sel, we, addr, wdata, input rdata);
    modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/timer_prescaler.sv
// Divides the core clock into count ticks: one tick every PRESCALE cycles while enabled.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign tick   = en & w_wrap;

    // Held at zero while disabled; restarted on any CTRL write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || !en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with sticky expiry flag and level interrupt.
// Optional compare/PWM output enabled by defining MMIO_TIMER_PWM_EN.
module mmio_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst,
    mmio_timer_if.slave  bus,
    output logic         irq,
    output logic         pwm_out
);
    ctrl_t            r_ctrl;
    logic [WIDTH-1:0] r_load;
    logic [WIDTH-1:0] r_count;
    logic             r_exp;

    logic [4:0] w_off;
    logic       w_wr;
    logic       w_wr_ctrl;
    logic       w_wr_load;
    logic       w_wr_count;
    logic       w_wr_status;
    logic       w_tick;
    logic       w_tick_ok;
    logic       w_expire;
    logic       w_unused;

    assign w_off       = {bus.addr[4:2], 2'b00};
    assign w_wr        = bus.sel & bus.we;
    assign w_wr_ctrl   = w_wr & (w_off == TMR_CTRL);
    assign w_wr_load   = w_wr & (w_off == TMR_LOAD);
    assign w_wr_count  = w_wr & (w_off == TMR_COUNT);
    assign w_wr_status = w_wr & (w_off == TMR_STATUS);
    assign w_unused    = &{1'b0, bus.addr[ADDR_W-1:5], bus.addr[1:0]};

    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (r_ctrl.en),
        .clr  (w_wr_ctrl),
        .tick (w_tick)
    );

    // Writing EN=0 cancels a coincident tick; a COUNT write overrides the tick entirely.
    assign w_tick_ok = w_tick & ~(w_wr_ctrl & ~bus.wdata[CTRL_EN]);
    assign w_expire  = w_tick_ok & ~w_wr_count & (r_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= '{ie: bus.wdata[CTRL_IE], ar: bus.wdata[CTRL_AR], en: bus.wdata[CTRL_EN]};
        end else if (w_expire && !r_ctrl.ar) begin
            r_ctrl.en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load <= '0;
        end else if (w_wr_load) begin
            r_load <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= bus.wdata;
        end else if (w_tick_ok) begin
            if (r_count != '0) begin
                r_count <= r_count - WIDTH'(1);
            end else if (r_ctrl.ar) begin
                r_count <= r_load;
            end
        end
    end

    // Set wins over write-one-to-clear on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exp <= 1'b0;
        end else if (w_expire) begin
            r_exp <= 1'b1;
        end else if (w_wr_status && bus.wdata[0]) begin
            r_exp <= 1'b0;
        end
    end

`ifdef MMIO_TIMER_PWM_EN
    logic [WIDTH-1:0] r_cmp;
    logic             r_pwm;
    logic             w_wr_cmp;

    assign w_wr_cmp = w_wr & (w_off == TMR_CMP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmp <= '0;
            r_pwm <= 1'b0;
        end else begin
            if (w_wr_cmp) begin
                r_cmp <= bus.wdata;
            end
            r_pwm <= r_ctrl.en & (r_count < r_cmp);
        end
    end

    assign pwm_out = r_pwm;
`else
    assign pwm_out = 1'b0;
`endif

    // Zero-latency read mux for the single-cycle core.
    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (w_off)
                TMR_CTRL:   bus.rdata = WIDTH'(r_ctrl);
                TMR_LOAD:   bus.rdata = r_load;
                TMR_COUNT:  bus.rdata = r_count;
                TMR_STATUS: bus.rdata = WIDTH'(r_exp);
`ifdef MMIO_TIMER_PWM_EN
                TMR_CMP:    bus.rdata = r_cmp;
`endif
                default:    bus.rdata = '0;
            endcase
        end
    end

    assign irq = r_exp & r_ctrl.ie;

endmodule
